// File: rtl/chain_control_egr_reg_pkg.sv
// chain_control_egr_reg_pkg: word map, writable masks and FSM encodings for the egress register bank
package chain_control_egr_reg_pkg;

    localparam int W_AP_CTRL           = 0;
    localparam int W_EXTIF0_BASE_L     = 1;
    localparam int W_EXTIF0_BASE_H     = 2;
    localparam int W_EXTIF0_OFFSET     = 3;
    localparam int W_EXTIF0_STRIDE     = 4;
    localparam int W_EXTIF0_SIZE       = 5;
    localparam int W_EXTIF1_BASE_L     = 6;
    localparam int W_EXTIF1_BASE_H     = 7;
    localparam int W_EXTIF_CTRL        = 8;
    localparam int W_EXTIF1_OFFSET     = 9;
    localparam int W_EXTIF1_STRIDE     = 10;
    localparam int W_EXTIF1_SIZE       = 11;
    localparam int W_FWD_CTRL          = 12;
    localparam int W_FWD_UPDATE        = 13;
    localparam int W_FWD_DATA0         = 14;
    localparam int W_FWD_DATA1         = 15;
    localparam int W_FWD_DATA2         = 16;
    localparam int W_FWD_SEL           = 17;
    localparam int W_FAULT_CTRL        = 18;
    localparam int W_EXTIF0_CMD_FAULT  = 19;
    localparam int W_EXTIF0_DATA_FAULT = 20;
    localparam int W_EXTIF1_CMD_FAULT  = 21;

    localparam int          N_WORDS = 32;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [31:0] M_FULL  = 32'hFFFF_FFFF;
    localparam logic [31:0] M_BYTE  = 32'h0000_00FF;
    localparam logic [31:0] M_NONE  = 32'h0000_0000;

    // bits that software may set in each control word; the rest read back as 0
    localparam logic [31:0] WR_MASK [N_WORDS] = '{
        32'h0000_0001,
        M_FULL, M_FULL, M_FULL, M_FULL, M_FULL, M_FULL, M_FULL,
        M_BYTE,
        M_FULL, M_FULL, M_FULL,
        M_BYTE,
        M_FULL, M_FULL, M_FULL, M_FULL,
        M_BYTE, M_BYTE,
        M_FULL, M_FULL, M_FULL,
        M_NONE, M_NONE, M_NONE, M_NONE, M_NONE,
        M_NONE, M_NONE, M_NONE, M_NONE, M_NONE
    };

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/chain_control_egr_axil_slv.sv
// chain_control_egr_axil_slv: registered AXI4-Lite handshake FSMs feeding a flat word store
module chain_control_egr_axil_slv
    import chain_control_egr_reg_pkg::*;
#(
    parameter int C_ADDR_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [C_ADDR_W-1:0] i_awaddr,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [31:0]         i_wdata,
    input  logic [3:0]          i_wstrb,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic                o_bvalid,
    input  logic                i_bready,
    input  logic [C_ADDR_W-1:0] i_araddr,
    input  logic                i_arvalid,
    output logic                o_arready,
    output logic [31:0]         o_rdata,
    output logic                o_rvalid,
    input  logic                i_rready,
    output logic                o_wr_en,
    output logic [4:0]          o_wr_idx,
    output logic [31:0]         o_wr_data,
    output logic [3:0]          o_wr_strb,
    output logic                o_rd_sel,
    output logic [4:0]          o_rd_idx,
    input  logic [31:0]         i_rd_data
);

    wr_state_t   r_wstate;
    rd_state_t   r_rstate;
    logic        r_awready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_aw_hs;
    logic        w_ar_hs;
    logic        w_unused_addr;

    assign w_aw_hs       = r_awready && i_awvalid && i_wvalid;
    assign w_ar_hs       = r_arready && i_arvalid;
    assign w_unused_addr = &{1'b0, i_awaddr[1:0], i_araddr[1:0]};

    assign o_awready = r_awready;
    assign o_wready  = r_awready;
    assign o_bvalid  = r_bvalid;
    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rdata   = r_rdata;

    // status region (addr[7]) is read-only, so such writes never reach the store
    assign o_wr_en   = w_aw_hs && !i_awaddr[7];
    assign o_wr_idx  = i_awaddr[6:2];
    assign o_wr_data = i_wdata;
    assign o_wr_strb = i_wstrb;
    assign o_rd_sel  = i_araddr[7];
    assign o_rd_idx  = i_araddr[6:2];

    // write path: ready is raised a cycle after both AW and W are seen, so no input reaches an output
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else if (r_wstate == W_IDLE) begin
            if (w_aw_hs) begin
                r_awready <= 1'b0;
                r_bvalid  <= 1'b1;
                r_wstate  <= W_RESP;
            end else begin
                r_awready <= i_awvalid && i_wvalid;
            end
        end else if (i_bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
        end
    end

    // read path: data captured at the AR handshake and held until the host takes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_rdata   <= i_rd_data;
                r_rstate  <= R_DATA;
            end else begin
                r_arready <= 1'b1;
            end
        end else if (i_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
        end
    end

endmodule

// File: rtl/chain_control_egr_reg_bank.sv
// chain_control_egr_reg_bank: AXI4-Lite control/status bank driving the egress reg_out vector
module chain_control_egr_reg_bank
    import chain_control_egr_reg_pkg::*;
#(
    parameter int C_ADDR_W = 8,
    parameter int C_DATA_W = 32
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [C_ADDR_W-1:0]   s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [C_DATA_W-1:0]   s_axi_wdata,
    input  logic [C_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [C_ADDR_W-1:0]   s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [C_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [1023:0]         reg_in,
    input  logic                  egr_forward_update_ack,
    output logic [1023:0]         reg_out
);

    logic        w_wr_en;
    logic [4:0]  w_wr_idx;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_rd_sel;
    logic [4:0]  w_rd_idx;
    logic [31:0] w_rd_data;
    logic [31:0] r_words [N_WORDS];

    chain_control_egr_axil_slv #(.C_ADDR_W(C_ADDR_W)) u_slv (
        .i_clk     (ap_clk),
        .i_rst     (ap_rst),
        .i_awaddr  (s_axi_awaddr),
        .i_awvalid (s_axi_awvalid),
        .o_awready (s_axi_awready),
        .i_wdata   (s_axi_wdata),
        .i_wstrb   (s_axi_wstrb),
        .i_wvalid  (s_axi_wvalid),
        .o_wready  (s_axi_wready),
        .o_bvalid  (s_axi_bvalid),
        .i_bready  (s_axi_bready),
        .i_araddr  (s_axi_araddr),
        .i_arvalid (s_axi_arvalid),
        .o_arready (s_axi_arready),
        .o_rdata   (s_axi_rdata),
        .o_rvalid  (s_axi_rvalid),
        .i_rready  (s_axi_rready),
        .o_wr_en   (w_wr_en),
        .o_wr_idx  (w_wr_idx),
        .o_wr_data (w_wr_data),
        .o_wr_strb (w_wr_strb),
        .o_rd_sel  (w_rd_sel),
        .o_rd_idx  (w_rd_idx),
        .i_rd_data (w_rd_data)
    );

    assign s_axi_bresp = OKAY;
    assign s_axi_rresp = OKAY;
    assign w_rd_data   = w_rd_sel ? reg_in[{w_rd_idx, 5'd0} +: 32] : r_words[w_rd_idx];

    // storage: the ack clear is issued first so a same-cycle host write to the update word overrides it
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < N_WORDS; i++) r_words[i] <= '0;
        end else begin
            if (egr_forward_update_ack) r_words[W_FWD_UPDATE] <= '0;
            if (w_wr_en) r_words[w_wr_idx] <= ((r_words[w_wr_idx] & ~strb_mask(w_wr_strb)) | (w_wr_data & strb_mask(w_wr_strb))) & WR_MASK[w_wr_idx];
        end
    end

    for (genvar k = 0; k < N_WORDS; k++) begin : g_out
        assign reg_out[32*k +: 32] = r_words[k];
    end

endmodule

// File: tb/tb_chain_control_egr_reg_bank.sv
// tb_chain_control_egr_reg_bank: randomized scoreboard bench for the egress register bank
module tb_chain_control_egr_reg_bank;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [7:0]    araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [1023:0] reg_in;
    logic          ack;
    logic [1023:0] reg_out;

    int            tests = 0;
    int            fails = 0;
    logic [31:0]   m_words [32];
    logic [31:0]   rin [32];
    logic [1:0]    bq [$];
    logic [31:0]   rq [$];

    always #5 clk = ~clk;

    chain_control_egr_reg_bank dut (
        .ap_clk                 (clk),
        .ap_rst                 (rst),
        .s_axi_awaddr           (awaddr),
        .s_axi_awvalid          (awvalid),
        .s_axi_awready          (awready),
        .s_axi_wdata            (wdata),
        .s_axi_wstrb            (wstrb),
        .s_axi_wvalid           (wvalid),
        .s_axi_wready           (wready),
        .s_axi_bresp            (bresp),
        .s_axi_bvalid           (bvalid),
        .s_axi_bready           (bready),
        .s_axi_araddr           (araddr),
        .s_axi_arvalid          (arvalid),
        .s_axi_arready          (arready),
        .s_axi_rdata            (rdata),
        .s_axi_rresp            (rresp),
        .s_axi_rvalid           (rvalid),
        .s_axi_rready           (rready),
        .reg_in                 (reg_in),
        .egr_forward_update_ack (ack),
        .reg_out                (reg_out)
    );

    function automatic logic [31:0] spec_mask(input int i);
        if (i == 0) return 32'h1;
        if (i == 8 || i == 12 || i == 17 || i == 18) return 32'hFF;
        if (i <= 21) return 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) m_words[idx][8*b +: 8] = d[8*b +: 8];
        m_words[idx] = m_words[idx] & spec_mask(idx);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_regout(input string name);
        int bad;
        bad = -1;
        tests++;
        for (int k = 0; k < 32; k++) if (bad < 0 && reg_out[32*k +: 32] !== m_words[k]) bad = k;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: reg_out word %0d got %h expected %h at %0t", name, bad, reg_out[32*bad +: 32], m_words[bad], $time);
        end
    endtask

    // monitor: every completed B or R beat is matched against the oldest expectation
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (bq.size() == 0) chk("unexpected_bvalid", 32'd1, 32'd0);
            else chk("bresp", bresp, bq.pop_front());
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
            else begin
                chk("rdata", rdata, rq.pop_front());
                chk("rresp", rresp, 32'd0);
            end
        end
    end

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s,
                      input bit hi = 0, input int aw_lead = 0, input int b_hold = 0, input bit ack_hs = 0);
        int n;
        logic [4:0] ix;
        ix = idx[4:0];
        awaddr = {hi, ix, 2'($urandom())};
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = (aw_lead == 0);
        bready = (b_hold == 0);
        for (int i = 0; i < aw_lead; i++) begin
            @(negedge clk);
            chk("aw_alone_no_ready", {awready, wready}, 32'd0);
        end
        if (aw_lead > 0) begin
            @(posedge clk);
            #1 wvalid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 20);
        chk("aw_w_ready", {awready, wready}, 32'd3);
        if (ack_hs) ack = 1'b1;
        bq.push_back(2'b00);
        chk_regout("pre_write_hold");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        ack = 1'b0;
        if (ack_hs) m_words[13] = 32'h0;
        if (!hi) m_write(idx, d, s);
        @(negedge clk);
        chk_regout("write_latency");
        for (int i = 0; i < b_hold; i++) begin
            chk("bvalid_held", bvalid, 32'd1);
            chk_regout("single_update");
            @(negedge clk);
        end
        if (b_hold > 0) begin
            @(posedge clk);
            #1 bready = 1'b1;
            @(negedge clk);
        end
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid_seen", bvalid, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int widx, input int r_hold = 0);
        int n;
        logic [5:0] ix;
        logic [31:0] e;
        ix = widx[5:0];
        araddr = {ix, 2'($urandom())};
        arvalid = 1'b1;
        rready = (r_hold == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arready && n < 20);
        chk("arready", arready, 32'd1);
        e = (widx >= 32) ? rin[widx-32] : m_words[widx];
        rq.push_back(e);
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < r_hold; i++) begin
            chk("rvalid_held", rvalid, 32'd1);
            chk("rdata_held", rdata, e);
            @(negedge clk);
        end
        if (r_hold > 0) begin
            @(posedge clk);
            #1 rready = 1'b1;
            @(negedge clk);
        end
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_seen", rvalid, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old5;
        int n;
        int op;
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; ack = 0;
        for (int k = 0; k < 32; k++) begin
            rin[k] = $urandom();
            reg_in[32*k +: 32] = rin[k];
            m_words[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 32'd0);
        chk("rst_valid", {bvalid, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk_regout("rst_regout");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int w = 0; w < 64; w++) rd(w);

        wr(1, 32'hDEADBEEF, 4'b0101);
        chk("w1_strobed", reg_out[63:32], 32'h00AD00EF);
        rd(1);

        wr(0, 32'hFFFFFFFF, 4'hF);
        wr(8, 32'hFFFFFFFF, 4'hF);
        wr(17, 32'hFFFFFFFF, 4'hF);
        wr(25, 32'hFFFFFFFF, 4'hF);
        chk("w0_apstart", reg_out[31:0], 32'h1);
        chk("w8_byte", reg_out[287:256], 32'hFF);
        chk("w17_byte", reg_out[575:544], 32'hFF);
        chk("w25_ro", reg_out[831:800], 32'h0);
        rd(0); rd(8); rd(17); rd(25);

        wr(3, 32'hA5A5_0F0F, 4'hF, 0, 3, 5);
        wr(4, 32'h1234_5678, 4'hF, 1);
        rd(4);

        wr(13, 32'h1, 4'hF);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        m_words[13] = 32'h0;
        @(negedge clk);
        chk("ack_clear", reg_out[447:416], 32'h0);
        @(posedge clk);
        #1;
        wr(13, 32'h2, 4'hF, 0, 0, 0, 1);
        chk("write_beats_ack", reg_out[447:416], 32'h2);

        wr(5, $urandom(), 4'hF);
        old5 = m_words[5];
        awaddr = 8'h14; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!awready && n < 20);
        chk("concurrent_awready", awready, 32'd1);
        bq.push_back(2'b00);
        araddr = 8'h14; arvalid = 1'b1; rready = 1'b0;
        chk("concurrent_arready", arready, 32'd1);
        rq.push_back(old5);
        @(posedge clk);
        #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        m_write(5, 32'h55, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("concurrent_rvalid_held", rvalid, 32'd1);
            chk("concurrent_old_data", rdata, old5);
        end
        chk_regout("concurrent_write");
        @(posedge clk);
        #1 rready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rd(5, 2);
        chk("w5_new", reg_out[191:160], 32'h55);

        for (int t = 0; t < 80; t++) begin
            op = $urandom_range(0, 9);
            if (op < 5) wr($urandom_range(0, 31), $urandom(), 4'($urandom()), ($urandom_range(0, 7) == 0));
            else if (op < 9) rd($urandom_range(0, 63), $urandom_range(0, 1));
            else begin
                ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
                m_words[13] = 32'h0;
                @(negedge clk);
                chk_regout("rand_ack");
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        chk("queues_drained", bq.size() + rq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
